// File: rtl/mem_pkg.sv
// Shared definitions for the HKRMIPS memory-access stage: op encodings,
// exception codes, FSM state encoding and op-class helpers.
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_e;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  function automatic logic is_load(input mem_op_e op);
    case (op)
      MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: is_load = 1'b1;
      default:                                  is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_e op);
    case (op)
      MEM_SB, MEM_SH, MEM_SW: is_store = 1'b1;
      default:                is_store = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables, store-data replication,
// misalignment detection and load extraction with sign/zero extension.
module mem_align
  import mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  output logic [31:0] load_data
);

  mem_op_e     op_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign op_s   = mem_op_e'(op);
  assign byte_s = rdata[{addr_lo, 3'b000} +: 8];
  assign half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Byte enables and misalignment per access size.
  always_comb begin
    be       = 4'b0000;
    misalign = 1'b0;
    case (op_s)
      MEM_LB, MEM_LBU, MEM_SB: begin
        be       = 4'b0001 << addr_lo;
        misalign = 1'b0;
      end
      MEM_LH, MEM_LHU, MEM_SH: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      MEM_LW, MEM_SW: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      default: begin
        be       = 4'b0000;
        misalign = 1'b0;
      end
    endcase
  end

  // Store data replicated across every lane the access may land on.
  always_comb begin
    wdata_rep = wdata;
    case (op_s)
      MEM_SB:  wdata_rep = {4{wdata[7:0]}};
      MEM_SH:  wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  // Load lane selection and extension.
  always_comb begin
    load_data = 32'h0000_0000;
    case (op_s)
      MEM_LB:  load_data = {{24{byte_s[7]}}, byte_s};
      MEM_LBU: load_data = {24'h00_0000, byte_s};
      MEM_LH:  load_data = {{16{half_s[15]}}, half_s};
      MEM_LHU: load_data = {16'h0000, half_s};
      MEM_LW:  load_data = rdata;
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// HKRMIPS memory-access stage: request/ack data bus, single-cycle writeback
// pulse, bus timeout. HKRMIPS_MEM_ADDR_EXC_EN enables AdEL/AdES on misalignment.
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [3:0]  ex_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  output logic        ex_ready,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_badvaddr
);

  localparam int unsigned CNT_W = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  mem_op_e          op_r;
  logic [4:0]       rd_r;
  logic [31:0]      addr_r;
  logic             kill_r;

  mem_op_e     ex_op_s;
  mem_op_e     al_op_s;
  logic [1:0]  al_addr_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_rep_s;
  logic        misalign_s;
  logic [31:0] load_data_s;
  logic        accept_s;
  logic        addr_exc_s;
  logic        killed_s;

  assign ex_op_s  = mem_op_e'(ex_op);
  assign ex_ready = (state_r == ST_IDLE);
  assign accept_s = ex_valid & ex_ready & ~flush;
  assign killed_s = kill_r | flush;

`ifdef HKRMIPS_MEM_ADDR_EXC_EN
  assign addr_exc_s = misalign_s;
`else
  // Misaligned low bits are simply ignored by the lane logic.
  assign addr_exc_s = misalign_s & 1'b0;
`endif

  // Aligner sees the incoming op while idle and the in-flight op during BUS.
  always_comb begin
    al_op_s   = ex_op_s;
    al_addr_s = ex_addr[1:0];
    if (state_r == ST_BUS) begin
      al_op_s   = op_r;
      al_addr_s = addr_r[1:0];
    end else begin
      al_op_s   = ex_op_s;
      al_addr_s = ex_addr[1:0];
    end
  end

  mem_align u_align (
    .op        (al_op_s),
    .addr_lo   (al_addr_s),
    .wdata     (ex_wdata),
    .rdata     (bus_rdata),
    .be        (be_s),
    .wdata_rep (wdata_rep_s),
    .misalign  (misalign_s),
    .load_data (load_data_s)
  );

  // Stage FSM with all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      op_r         <= MEM_NONE;
      rd_r         <= 5'd0;
      addr_r       <= 32'h0000_0000;
      kill_r       <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'h0000_0000;
      bus_be       <= 4'b0000;
      bus_wdata    <= 32'h0000_0000;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'h0000_0000;
      exc_valid    <= 1'b0;
      exc_code     <= 5'd0;
      exc_badvaddr <= 32'h0000_0000;
    end else begin
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      exc_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r  <= '0;
          kill_r <= 1'b0;
          if (accept_s) begin
            if (is_load(ex_op_s) || is_store(ex_op_s)) begin
              if (addr_exc_s) begin
                exc_valid    <= 1'b1;
                exc_code     <= is_store(ex_op_s) ? EXC_ADES : EXC_ADEL;
                exc_badvaddr <= ex_addr;
              end else begin
                bus_req   <= 1'b1;
                bus_we    <= is_store(ex_op_s);
                bus_addr  <= {ex_addr[31:2], 2'b00};
                bus_be    <= be_s;
                bus_wdata <= wdata_rep_s;
                op_r      <= ex_op_s;
                rd_r      <= ex_rd;
                addr_r    <= ex_addr;
                state_r   <= ST_BUS;
              end
            end else begin
              wb_valid <= 1'b1;
              wb_we    <= (ex_rd != 5'd0);
              wb_rd    <= ex_rd;
              wb_data  <= ex_result;
            end
          end
        end
        ST_BUS: begin
          if (flush) begin
            kill_r <= 1'b1;
          end
          // Ack wins over a timeout expiring in the same cycle.
          if (bus_ack) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            cnt_r   <= '0;
            state_r <= ST_IDLE;
            if (!killed_s) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_r;
              if (is_load(op_r)) begin
                wb_we   <= (rd_r != 5'd0);
                wb_data <= load_data_s;
              end else begin
                wb_we   <= 1'b0;
                wb_data <= 32'h0000_0000;
              end
            end
          end else if (cnt_r == CNT_LAST) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            cnt_r   <= '0;
            state_r <= ST_IDLE;
            if (!killed_s) begin
              exc_valid    <= 1'b1;
              exc_code     <= EXC_DBE;
              exc_badvaddr <= addr_r;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected wb/exc records,
// a negedge monitor pops and compares every pulse.
module tb_mem_access;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_ready;
  logic        flush;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_badvaddr;

  typedef struct {
    logic        is_exc;
    logic        we;
    logic [4:0]  rd;
    logic        chk_data;
    logic [31:0] data;
    logic [4:0]  code;
    logic [31:0] badv;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  mem_access #(.BUS_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .ex_rd        (ex_rd),
    .ex_result    (ex_result),
    .ex_ready     (ex_ready),
    .flush        (flush),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_badvaddr (exc_badvaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk_wb(input logic we, input logic [4:0] rd,
                                 input logic cd, input logic [31:0] data);
    exp_t e;
    e.is_exc = 1'b0; e.we = we; e.rd = rd; e.chk_data = cd; e.data = data;
    e.code = 5'd0; e.badv = 32'h0;
    return e;
  endfunction

  function automatic exp_t mk_exc(input logic [4:0] code, input logic [31:0] badv);
    exp_t e;
    e.is_exc = 1'b1; e.we = 1'b0; e.rd = 5'd0; e.chk_data = 1'b0; e.data = 32'h0;
    e.code = code; e.badv = badv;
    return e;
  endfunction

  // Monitor: every output pulse must match the oldest expected record.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid || exc_valid) begin
        chk("pulse_exclusive", {31'd0, wb_valid & exc_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, wb_valid, exc_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_exc) begin
            chk("exc_valid", {31'd0, exc_valid}, 32'd1);
            chk("exc_code", {27'd0, exc_code}, {27'd0, e.code});
            chk("exc_badvaddr", exc_badvaddr, e.badv);
          end else begin
            chk("wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            if (e.chk_data) chk("wb_data", wb_data, e.data);
          end
        end
      end
    end
  end

  // Present one instruction for exactly one accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [31:0] res);
    ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_wdata = wdata;
    ex_rd = rd; ex_result = res;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = 4'd0; ex_addr = 32'h0; ex_wdata = 32'h0;
    ex_rd = 5'd0; ex_result = 32'h0;
  endtask

  task automatic respond(input int waits, input logic [31:0] rdata);
    for (int i = 0; i < waits; i++) begin
      @(posedge clk); #1;
      chk("hold_req", {31'd0, bus_req}, 32'd1);
      chk("hold_not_ready", {31'd0, ex_ready}, 32'd0);
    end
    bus_ack = 1'b1; bus_rdata = rdata;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    chk("ack_req_drop", {31'd0, bus_req}, 32'd0);
    chk("ack_ready", {31'd0, ex_ready}, 32'd1);
  endtask

  task automatic check_bus(input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic chk_wd,
                           input logic [31:0] wd);
    chk("bus_req", {31'd0, bus_req}, 32'd1);
    chk("bus_we", {31'd0, bus_we}, {31'd0, we});
    chk("bus_addr", bus_addr, addr);
    chk("bus_be", {28'd0, bus_be}, {28'd0, be});
    if (chk_wd) chk("bus_wdata", bus_wdata, wd);
    chk("busy_not_ready", {31'd0, ex_ready}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_op = 4'd0; ex_addr = 32'h0;
    ex_wdata = 32'h0; ex_rd = 5'd0; ex_result = 32'h0; flush = 1'b0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_exc_code", {27'd0, exc_code}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);

    // Pass-through ops
    exp_q.push_back(mk_wb(1'b1, 5'd3, 1'b1, 32'h1234_5678));
    issue(MEM_NONE, 32'h0, 32'h0, 5'd3, 32'h1234_5678);
    chk("none_wb_t1", {31'd0, wb_valid}, 32'd1);
    exp_q.push_back(mk_wb(1'b0, 5'd0, 1'b1, 32'h1234_5678));
    issue(MEM_NONE, 32'h0, 32'h0, 5'd0, 32'h1234_5678);

    // Byte loads
    exp_q.push_back(mk_wb(1'b1, 5'd5, 1'b1, 32'hFFFF_FF80));
    issue(MEM_LB, 32'h0000_1003, 32'h0, 5'd5, 32'h0);
    check_bus(1'b0, 32'h0000_1000, 4'b1000, 1'b0, 32'h0);
    respond(2, 32'h80AA_BBCC);
    exp_q.push_back(mk_wb(1'b1, 5'd5, 1'b1, 32'h0000_0080));
    issue(MEM_LBU, 32'h0000_1003, 32'h0, 5'd5, 32'h0);
    respond(2, 32'h80AA_BBCC);

    // Stores
    exp_q.push_back(mk_wb(1'b0, 5'd7, 1'b0, 32'h0));
    issue(MEM_SH, 32'h0000_2002, 32'hDEAD_BEEF, 5'd7, 32'h0);
    check_bus(1'b1, 32'h0000_2000, 4'b1100, 1'b1, 32'hBEEF_BEEF);
    respond(1, 32'h0);
    exp_q.push_back(mk_wb(1'b0, 5'd1, 1'b0, 32'h0));
    issue(MEM_SB, 32'h0000_5001, 32'h0000_00A5, 5'd1, 32'h0);
    check_bus(1'b1, 32'h0000_5000, 4'b0010, 1'b1, 32'hA5A5_A5A5);
    respond(0, 32'h0);
    exp_q.push_back(mk_wb(1'b0, 5'd1, 1'b0, 32'h0));
    issue(MEM_SW, 32'h0000_6000, 32'h0102_0304, 5'd1, 32'h0);
    check_bus(1'b1, 32'h0000_6000, 4'b1111, 1'b1, 32'h0102_0304);
    respond(0, 32'h0);

    // Half loads
    exp_q.push_back(mk_wb(1'b1, 5'd10, 1'b1, 32'hFFFF_8001));
    issue(MEM_LH, 32'h0000_4002, 32'h0, 5'd10, 32'h0);
    check_bus(1'b0, 32'h0000_4000, 4'b1100, 1'b0, 32'h0);
    respond(0, 32'h8001_7FFF);
    exp_q.push_back(mk_wb(1'b1, 5'd11, 1'b1, 32'h0000_7FFF));
    issue(MEM_LHU, 32'h0000_4000, 32'h0, 5'd11, 32'h0);
    check_bus(1'b0, 32'h0000_4000, 4'b0011, 1'b0, 32'h0);
    respond(0, 32'h8001_7FFF);

    // Misaligned word load
`ifdef HKRMIPS_MEM_ADDR_EXC_EN
    exp_q.push_back(mk_exc(5'd4, 32'h0000_3001));
    issue(MEM_LW, 32'h0000_3001, 32'h0, 5'd9, 32'h0);
    chk("adel_no_req", {31'd0, bus_req}, 32'd0);
    chk("adel_ready", {31'd0, ex_ready}, 32'd1);
    @(posedge clk); #1;
    chk("adel_no_req_later", {31'd0, bus_req}, 32'd0);
`else
    exp_q.push_back(mk_wb(1'b1, 5'd9, 1'b1, 32'h1122_3344));
    issue(MEM_LW, 32'h0000_3001, 32'h0, 5'd9, 32'h0);
    check_bus(1'b0, 32'h0000_3000, 4'b1111, 1'b0, 32'h0);
    respond(0, 32'h1122_3344);
`endif

    // Bus timeout: 4 BUS cycles without ack
    exp_q.push_back(mk_exc(5'd7, 32'h0000_7000));
    issue(MEM_LW, 32'h0000_7000, 32'h0, 5'd4, 32'h0);
    chk("to_req_t1", {31'd0, bus_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("to_req_hold", {31'd0, bus_req}, 32'd1);
    end
    @(posedge clk); #1;
    chk("to_req_drop", {31'd0, bus_req}, 32'd0);
    chk("to_ready", {31'd0, ex_ready}, 32'd1);

    // Ack in the expiry cycle counts as success
    exp_q.push_back(mk_wb(1'b1, 5'd8, 1'b1, 32'h0000_0055));
    issue(MEM_LBU, 32'h0000_9002, 32'h0, 5'd8, 32'h0);
    respond(3, 32'h0055_0000);

    // Flush mid-BUS: transaction completes silently
    issue(MEM_LW, 32'h0000_8000, 32'h0, 5'd6, 32'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_no_abort", {31'd0, bus_req}, 32'd1);
    respond(0, 32'hCAFE_F00D);
    // Flush in IDLE blocks acceptance
    flush = 1'b1;
    issue(MEM_NONE, 32'h0, 32'h0, 5'd2, 32'h5555_5555);
    flush = 1'b0;
    chk("flush_idle_no_wb", {31'd0, wb_valid}, 32'd0);

    // Reset mid-transaction; a late ack must be ignored
    issue(MEM_LW, 32'h0000_A000, 32'h0, 5'd2, 32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_req", {31'd0, bus_req}, 32'd0);
    chk("rst_mid_ready", {31'd0, ex_ready}, 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h1234_0000;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    chk("late_ack_no_wb", {31'd0, wb_valid}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the HKRMIPS pipeline, directly downstream of the execute stage. It takes one instruction per handshake from execute, performs the load or store over a simple request/acknowledge data bus (byte enables, sign/zero extension, little-endian lanes), and presents a single-cycle writeback record to the writeback stage. Non-memory instructions pass through with one cycle of latency. It stalls execute while a bus transaction is outstanding and reports address and bus-timeout exceptions.

## Interface
- BUS_TIMEOUT, 255, cycles in BUS state without `bus_ack` before a data-bus-error exception; legal range 1..65535
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- ex_valid  in  1  execute presents an instruction
- ex_op  in  4  MEM_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW
- ex_addr  in  32  effective address (loads and stores)
- ex_wdata  in  32  store data; low byte or half carries SB/SH data
- ex_rd  in  5  destination register
- ex_result  in  32  ALU result for MEM_NONE
- ex_ready  out  1  stage can accept; equals state==IDLE
- flush  in  1  kill the current and incoming instruction
- bus_req, bus_we  out  1  request and write strobe
- bus_addr  out  32  word address, bits [1:0] = 0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  transaction complete
- bus_rdata  in  32  read data, valid with `bus_ack`
- wb_valid, wb_we  out  1  retire pulse; register write enable
- wb_rd  out  5;  wb_data  out  32
- exc_valid  out  1  exception pulse
- exc_code  out  5  4 = AdEL, 5 = AdES, 7 = DBE
- exc_badvaddr  out  32  faulting `ex_addr`

## Operation
- States: IDLE and BUS.
- Handshake: accept = ex_valid & ex_ready & ~flush.
- IDLE, accept of MEM_NONE:
  - next cycle: wb_valid=1, wb_we=(ex_rd!=0), wb_data=ex_result.
- IDLE, accept of a memory op (no exception): register bus signals, bus_req=1, go to BUS.
- Byte lanes:
  - byte: be = 1<<addr[1:0]
  - half: be = addr[1] ? 1100 : 0011
  - word: be = 1111
  - store data: byte replicated ×4, half replicated ×2.
- Loads: select lane by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend.
- Stores retire with wb_valid=1, wb_we=0.
- BUS state:
  - All bus outputs are held stable until ack.
  - On bus_ack: bus_req=0 next cycle, wb pulse next cycle, return to IDLE, clear timeout counter.
  - Counter reaches BUS_TIMEOUT with no ack: drop bus_req, pulse exc_valid with code 7 and exc_badvaddr, no wb, go to IDLE.
- flush:
  - IDLE: nothing is accepted.
  - BUS: the transaction is not aborted. It runs to ack or timeout, but its wb and exc pulses are suppressed (sticky kill bit).
- Simultaneous: ack in the same cycle the counter expires counts as success.
- Reset, including mid-transaction:
  - state=IDLE, counter=0.
  - bus_req=bus_we=0, bus_addr=bus_be=bus_wdata=0.
  - wb_valid=wb_we=0, wb_rd=0, wb_data=0.
  - exc_valid=0, exc_code=0, exc_badvaddr=0.
  - ex_ready=1 in the cycle after reset deasserts.

## Timing
- Accept at cycle T; MEM_NONE wb at T+1.
- Memory op: bus_req high T+1 through ack cycle A (inclusive); wb at A+1. Minimum load-use latency 2.
- ex_ready is low from T+1 through A; next accept at A+1 earliest.
- All outputs are registered except ex_ready.
- wb_valid and exc_valid are one-cycle pulses and never both high.

## Configuration
- `HKRMIPS_MEM_ADDR_EXC_EN` defined: misaligned half/word raises an exception at T+1 and no bus request is issued.
  - Load: AdEL (4). Store: AdES (5).
  - exc_badvaddr = ex_addr.
- Undefined: the misaligned low address bits are ignored (forced 0 for halfword bit 0 and word bits [1:0]) and the access proceeds normally; exc codes 4/5 are never produced.

## Structure
- Shared package `mem_pkg`: MEM_* op encodings, EXC_ADEL/EXC_ADES/EXC_DBE, state encoding.
- Sub-module `mem_align` (combinational): computes be, replicated wdata, misalign flag, and the extended load result from op, addr[1:0] and rdata. Instantiated once.
- Timeout counter width is clog2(BUS_TIMEOUT+1).

## Test plan
- MEM_NONE, ex_result=0x1234_5678, rd=3 -> wb_valid at T+1, wb_data=0x1234_5678, wb_we=1. Same with rd=0 -> wb_we=0.
- LB addr=0x1003, ack after 2 cycles with rdata=0x80AA_BBCC -> bus_be=1000, bus_addr=0x1000, wb_data=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- SH addr=0x2002, wdata=0xDEAD_BEEF -> bus_we=1, be=1100, bus_wdata=0xBEEF_BEEF; ex_ready low until ack; wb_valid=1, wb_we=0.
- LW addr=0x3001 with macro defined -> exc_valid at T+1, code 4, badvaddr 0x3001, bus_req never high. Without macro -> bus_addr=0x3000, normal load.
- BUS_TIMEOUT=4, no ack -> bus_req drops, exc code 7; flush asserted mid-BUS with ack -> no wb pulse.
- rst_n low during BUS -> next cycle bus_req=0, ex_ready=1, and a later ack is ignored.
